// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: scan/refresh controller for a 64x32 HUB75 panel with BCM output-enable timing.
// Optional macro HUB75_BRIGHTNESS_EN adds a global brightness input that trims each lit window.
module hub75_scan_ctrl #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 4,
  parameter int PLANES   = 4,
  parameter int BASE_ON  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]          brightness,
`endif
  output logic [11:0]         pixel_addr,
  input  logic [23:0]         pixel_data,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                r2,
  output logic                g2,
  output logic                b2,
  output logic                hub_clk,
  output logic                hub_lat,
  output logic                hub_oe_n,
  output logic [ROW_BITS-1:0] hub_row,
  output logic                busy,
  output logic                frame_done
);

  localparam int COL_W  = $clog2(COLS);
  localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int MAX_ON = BASE_ON << (PLANES - 1);
  localparam int CNT_W  = $clog2(MAX_ON + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_TOP, FETCH_BOT, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY
  } state_t;

  state_t              state, state_d;
  logic [COL_W-1:0]    col;
  logic [ROW_BITS-1:0] row;
  logic [PL_W-1:0]     plane;
  logic [CNT_W-1:0]    cnt;
  logic [23:0]         top_rgb, bot_rgb;

  logic [CNT_W-1:0]    disp_len;
  logic                disp_last, last_col, last_plane, last_row, frame_end, lit;
  logic [2:0]          bit_sel;

  assign disp_len   = CNT_W'(BASE_ON) << plane;
  assign disp_last  = (cnt == disp_len - 1'b1);
  assign last_col   = (col == COL_W'(COLS - 1));
  assign last_plane = (plane == PL_W'(PLANES - 1));
  assign last_row   = (row == {ROW_BITS{1'b1}});
  assign frame_end  = last_plane && last_row;
  assign bit_sel    = 3'(8 - PLANES) + 3'(plane);

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]         bright_q;
  logic [CNT_W+7:0]   on_prod;
  logic [CNT_W-1:0]   on_thresh;
  assign on_prod   = (CNT_W+8)'(disp_len) * (CNT_W+8)'(bright_q);
  assign on_thresh = on_prod[CNT_W+7:8];
  assign lit       = (cnt < on_thresh);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // en is only consulted in IDLE and at the frame boundary, so a frame always completes.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (en) state_d = FETCH_TOP;
      FETCH_TOP: state_d = FETCH_BOT;
      FETCH_BOT: state_d = SHIFT_LO;
      SHIFT_LO:  state_d = SHIFT_HI;
      SHIFT_HI:  state_d = last_col ? BLANK : FETCH_TOP;
      BLANK:     state_d = LATCH;
      LATCH:     state_d = DISPLAY;
      DISPLAY:   if (disp_last) state_d = (frame_end && !en) ? IDLE : FETCH_TOP;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      plane   <= '0;
      cnt     <= '0;
      top_rgb <= '0;
      bot_rgb <= '0;
      hub_row <= '0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q <= '0;
`endif
    end else begin
      case (state)
        FETCH_TOP: top_rgb <= pixel_data;
        FETCH_BOT: bot_rgb <= pixel_data;
        SHIFT_HI:  col <= last_col ? '0 : col + 1'b1;
        LATCH: begin
          hub_row <= row;
          cnt     <= '0;
`ifdef HUB75_BRIGHTNESS_EN
          bright_q <= brightness;
`endif
        end
        DISPLAY: begin
          cnt <= cnt + 1'b1;
          if (disp_last) begin
            if (last_plane) begin
              plane <= '0;
              row   <= row + 1'b1;
            end else begin
              plane <= plane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel request: pixel_addr is valid only in FETCH_TOP/FETCH_BOT and the generator must
  // return pixel_data combinationally in that same cycle; there is no stall path.
  always_comb begin
    pixel_addr = '0;
    {r1, g1, b1, r2, g2, b2} = '0;
    hub_clk    = 1'b0;
    hub_lat    = 1'b0;
    hub_oe_n   = 1'b1;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      FETCH_TOP: pixel_addr = 12'({1'b0, row, col});
      FETCH_BOT: pixel_addr = 12'({1'b1, row, col});
      SHIFT_LO, SHIFT_HI: begin
        r1 = top_rgb[16 + 32'(bit_sel)];
        g1 = top_rgb[8 + 32'(bit_sel)];
        b1 = top_rgb[32'(bit_sel)];
        r2 = bot_rgb[16 + 32'(bit_sel)];
        g2 = bot_rgb[8 + 32'(bit_sel)];
        b2 = bot_rgb[32'(bit_sel)];
        hub_clk = (state == SHIFT_HI);
      end
      LATCH:   hub_lat = 1'b1;
      DISPLAY: begin
        hub_oe_n   = !lit;
        frame_done = disp_last && frame_end;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: randomized bench checking hub75_scan_ctrl against a cycle-position model.
// Define HUB75_BRIGHTNESS_EN for both bench and RTL to exercise the brightness port.
`timescale 1ns/1ps
module tb_hub75_scan_ctrl;

  localparam int COLS       = 64;
  localparam int ROW_BITS   = 4;
  localparam int PLANES     = 4;
  localparam int BASE_ON    = 8;
  localparam int ROWS       = 1 << ROW_BITS;
  localparam int SHIFT_LEN  = 4 * COLS + 2;
  localparam int ROW_PERIOD = PLANES * SHIFT_LEN + BASE_ON * ((1 << PLANES) - 1);
  localparam int FRAME      = ROWS * ROW_PERIOD;

  logic                clk;
  logic                rst;
  logic                en;
  logic [7:0]          brightness;
  logic [11:0]         pixel_addr;
  logic [23:0]         pixel_data;
  logic                r1, g1, b1, r2, g2, b2;
  logic                hub_clk, hub_lat, hub_oe_n;
  logic [ROW_BITS-1:0] hub_row;
  logic                busy, frame_done;

  logic [23:0] img [0:2047];
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int exp_row_lat;
  int bright_eff;
  int first_lat_k;
  int clk_rises;

  logic        e_addr_v, e_data_v, e_hclk, e_lat, e_oe_n, e_fd;
  logic [11:0] e_addr;
  logic [5:0]  e_data;
  int          e_latch_row;

  hub75_scan_ctrl #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_ON(BASE_ON)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n), .hub_row(hub_row),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pixel generator: a frame-buffer lookup.
  always_comb pixel_data = img[pixel_addr[10:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_row_lat = 0;
  endtask

  // Expected outputs for cycle k counted from the first FETCH_TOP of a run.
  task automatic predict(input int k);
    int f, row, o, p, len, c, ph, bi, d;
    logic [23:0] tp, bt;
    f = k % FRAME;
    row = f / ROW_PERIOD;
    o = f % ROW_PERIOD;
    p = 0;
    len = BASE_ON;
    while (o >= SHIFT_LEN + len) begin
      o = o - (SHIFT_LEN + len);
      p++;
      len = BASE_ON << p;
    end
    e_addr_v = 1'b0; e_addr = '0; e_data_v = 1'b0; e_data = '0; e_latch_row = -1;
    e_hclk = 1'b0; e_lat = 1'b0; e_oe_n = 1'b1; e_fd = 1'b0;
    if (o < 4 * COLS) begin
      c = o / 4;
      ph = o % 4;
      if (ph == 0) begin
        e_addr_v = 1'b1;
        e_addr = 12'(row * COLS + c);
      end else if (ph == 1) begin
        e_addr_v = 1'b1;
        e_addr = 12'(ROWS * COLS + row * COLS + c);
      end else begin
        tp = img[row * COLS + c];
        bt = img[ROWS * COLS + row * COLS + c];
        bi = 8 - PLANES + p;
        e_data_v = 1'b1;
        e_data = {tp[16 + bi], tp[8 + bi], tp[bi], bt[16 + bi], bt[8 + bi], bt[bi]};
        e_hclk = (ph == 3);
      end
    end else if (o == 4 * COLS + 1) begin
      e_lat = 1'b1;
      e_latch_row = row;
    end else if (o >= SHIFT_LEN) begin
      d = o - SHIFT_LEN;
      e_oe_n = !(d < ((len * bright_eff) >> 8));
      e_fd = (f == FRAME - 1);
    end
  endtask

  // Caller leaves en=1 with the DUT in IDLE; the next edge starts cycle 0.
  task automatic run(input int n_active, input int drop_k, input int n_idle);
    logic prev_hclk;
    prev_hclk = 1'b0;
    exp_q.delete();
    for (int f = 1; f * FRAME <= n_active; f++) exp_q.push_back(32'(f * FRAME - 1));
    first_lat_k = -1;
    clk_rises = 0;
    @(posedge clk);
    for (int k = 0; k < n_active + n_idle; k++) begin
      #1;
      if (k < n_active) begin
        predict(k);
        if (e_addr_v) check("pixel_addr", 32'(pixel_addr), 32'(e_addr));
        if (e_data_v) check("rgb_bits", 32'({r1, g1, b1, r2, g2, b2}), 32'(e_data));
        check("ctl", 32'({hub_clk, hub_lat, hub_oe_n, busy, frame_done}),
              32'({e_hclk, e_lat, e_oe_n, 1'b1, e_fd}));
      end else begin
        check("idle_ctl", 32'({hub_clk, hub_lat, hub_oe_n, busy, frame_done}), 32'(5'b00100));
      end
      check("hub_row", 32'(hub_row), 32'(exp_row_lat));
      if (frame_done) begin
        if (exp_q.size() == 0) check("frame_done_extra", 32'(k), 32'hFFFF_FFFF);
        else check("frame_done_cycle", 32'(k), exp_q.pop_front());
      end
      if (hub_lat && first_lat_k < 0) first_lat_k = k;
      if (hub_clk && !prev_hclk && first_lat_k < 0) clk_rises++;
      prev_hclk = hub_clk;
      if (k < n_active && e_latch_row >= 0) exp_row_lat = e_latch_row;
      if (k == drop_k) en = 1'b0;
      @(posedge clk);
    end
    check("frame_done_missing", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_bright(input int b);
    brightness = 8'(b);
`ifdef HUB75_BRIGHTNESS_EN
    bright_eff = b;
`else
    bright_eff = 256;
`endif
  endtask

  initial begin
    int rr, pp, dd, k_stop;
    rst = 1'b1;
    en = 1'b0;
    set_bright(255);
    for (int i = 0; i < 2048; i++) img[i] = 24'($urandom);

    do_reset();
    check("rst_oe_n", 32'(hub_oe_n), 32'd1);
    check("rst_addr", 32'(pixel_addr), 32'd0);
    check("rst_row", 32'(hub_row), 32'd0);
    check("rst_misc", 32'({hub_clk, hub_lat, busy, frame_done}), 32'd0);
    check("rst_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);

    for (int i = 0; i < 2048; i++) img[i] = (i < 1024) ? 24'hFF0000 : 24'h0000FF;
    en = 1'b1;
    run(2 * ROW_PERIOD, -1, 0);
    check("first_lat_cycle", 32'(first_lat_k + 1), 32'd258);
    check("clk_edges_before_lat", 32'(clk_rises), 32'd64);

    do_reset();
    for (int i = 0; i < 2048; i++) img[i] = (i < 1024) ? 24'h800000 : 24'($urandom);
    en = 1'b1;
    run(ROW_PERIOD, -1, 0);

    do_reset();
    for (int i = 0; i < 2048; i++) img[i] = 24'($urandom);
    set_bright($urandom_range(1, 255));
    en = 1'b1;
    run(2 * FRAME, FRAME + 5 * ROW_PERIOD + $urandom_range(0, ROW_PERIOD - 1), 20);
    check("idle_row_after_frame", 32'(hub_row), 32'(ROWS - 1));

    set_bright(255);
    do_reset();
    rr = $urandom_range(0, 3);
    pp = $urandom_range(0, PLANES - 1);
    dd = $urandom_range(0, (BASE_ON << pp) - 1);
    k_stop = rr * ROW_PERIOD + SHIFT_LEN + dd;
    for (int q = 0; q < pp; q++) k_stop += SHIFT_LEN + (BASE_ON << q);
    en = 1'b1;
    run(k_stop, -1, 0);
    #1;
    predict(k_stop);
    check("pre_rst_oe_n", 32'(hub_oe_n), 32'(e_oe_n));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_oe_n", 32'(hub_oe_n), 32'd1);
    check("mid_rst_lat", 32'(hub_lat), 32'd0);
    check("mid_rst_row", 32'(hub_row), 32'd0);
    check("mid_rst_addr", 32'(pixel_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    exp_row_lat = 0;
    run(ROW_PERIOD + SHIFT_LEN, -1, 0);

`ifdef HUB75_BRIGHTNESS_EN
    do_reset();
    set_bright(128);
    en = 1'b1;
    run(ROW_PERIOD, -1, 0);
    do_reset();
    set_bright(0);
    en = 1'b1;
    run(ROW_PERIOD, -1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Scan/refresh controller for the 64x32 HUB75 LED panel.
- Sequences the temperature pixel generator by issuing `pixel_addr` and capturing `pixel_data`.
- Shifts RGB bitplanes into the panel, latches them, and times output-enable with binary-coded modulation (BCM).
- Sits between the combinational pixel source and the panel connector pins.

Parameters:
- COLS, 64, pixels per shifted line; also the `pixel_addr` column range.
- ROW_BITS, 4, scan-row address width; the panel is driven 1/(2^ROW_BITS) scan.
- PLANES, 4, BCM bit depth; uses the PLANES MSBs of each 8-bit channel.
- BASE_ON, 8, `hub_oe_n`-low cycles for plane 0; plane p is lit for BASE_ON<<p cycles.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, run enable.
- pixel_addr, output, 12, {1'b0, ROW[4:0], COL[5:0]} request to the pixel generator.
- pixel_data, input, 24, RGB from the generator: [23:16]=R, [15:8]=G, [7:0]=B. Combinational, valid in the same cycle as `pixel_addr`.
- r1/g1/b1, output, 1 each, top-half data bits.
- r2/g2/b2, output, 1 each, bottom-half data bits.
- hub_clk, output, 1, panel shift clock.
- hub_lat, output, 1, panel latch.
- hub_oe_n, output, 1, panel output enable, active low.
- hub_row, output, ROW_BITS, panel row address A..D.
- busy, output, 1, high in any state except IDLE.
- frame_done, output, 1, one-cycle pulse when a full frame completes.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - `hub_oe_n`=1.
  - All other outputs 0, including `pixel_addr`=0 and `hub_row`=0.
  - Internal state: FSM=IDLE, row=0, plane=0, col=0.
- IDLE: `hub_oe_n`=1. Go to FETCH_TOP when `en`=1.
- Per column, 4 cycles:
  - FETCH_TOP: `pixel_addr`={1'b0, {1'b0,row}, col}. Register `pixel_data` into top_rgb at the end of the cycle.
  - FETCH_BOT: `pixel_addr`={1'b0, row+2^ROW_BITS, col}. Register into bot_rgb.
  - SHIFT_LO: drive r1/g1/b1/r2/g2/b2 from bit (8-PLANES+plane) of each channel; `hub_clk`=0.
  - SHIFT_HI: `hub_clk`=1 with data held. If col=COLS-1, go to BLANK; else col++ and go to FETCH_TOP.
- BLANK, 1 cycle: `hub_oe_n`=1, `hub_clk`=0.
- LATCH, 1 cycle: `hub_lat`=1, `hub_row`<=row, display counter cleared.
- DISPLAY: `hub_oe_n`=0 for exactly BASE_ON<<plane cycles, then `hub_oe_n`=1. Then:
  - plane < PLANES-1: plane++, col=0, go to FETCH_TOP.
  - plane = PLANES-1: plane=0, go to the next row.
  - Row wraps 2^ROW_BITS-1 -> 0. On wrap, pulse `frame_done` in the cycle DISPLAY exits; go to IDLE if `en`=0, else FETCH_TOP.
- `hub_oe_n` is high in every state except DISPLAY (no overlap of shifting and display).
- Row-plane period: 4*COLS + 2 + (BASE_ON<<plane) cycles.
- `en` deasserted mid-frame: the current frame completes, then the FSM goes to IDLE. `en` is sampled only at the frame boundary and in IDLE.
- `rst` mid-operation: immediate return to reset values on the next edge. No partial latch.
- Widths:
  - Display counter is sized for BASE_ON<<(PLANES-1).
  - col counter is $clog2(COLS) bits.
  - `pixel_addr`[11] is always 0.

Optional Feature:
- Macro: HUB75_BRIGHTNESS_EN.
- With macro:
  - Adds input port brightness[7:0], sampled in LATCH.
  - In DISPLAY, `hub_oe_n`=0 only while count < ((BASE_ON<<plane)*brightness)>>8.
  - DISPLAY duration is unchanged.
  - brightness=0 keeps `hub_oe_n`=1 for the whole frame.
- Without macro: no brightness port; full on-time as above.

Test Plan:
- Reset then `en`=1 (defaults) -> `pixel_addr` sequence 0x000, 0x400, 0x001, 0x401, …
  - 64 `hub_clk` rising edges before the first `hub_lat` pulse at cycle 258.
  - `hub_oe_n` low for exactly 8 cycles.
- `pixel_data`=0xFF0000 top and 0x0000FF bottom:
  - Every plane shifts r1=1, b2=1, others 0.
  - `pixel_data`=0x80_0000 gives r1=1 only on plane 3; `hub_oe_n`-low for plane 3 is 64 cycles.
- Run a full frame -> `hub_row` steps 0..15 then wraps to 0.
  - `frame_done` is a single pulse after 16*(4*(4*64+2)+8+16+32+64) = 18432 cycles.
- Drop `en` during row 5 -> frame finishes through row 15, `frame_done` pulses, FSM goes to IDLE.
  - In IDLE: `busy`=0, `hub_oe_n`=1, no further `hub_clk` edges.
- Assert `rst` mid-DISPLAY -> next edge: `hub_oe_n`=1, `hub_lat`=0, `hub_row`=0, `pixel_addr`=0.
  - Restart begins at row 0, plane 0.
- HUB75_BRIGHTNESS_EN:
  - brightness=128 -> plane 2 has 16 of 32 DISPLAY cycles with `hub_oe_n`=0.
  - brightness=0 -> `hub_oe_n` never low.
